output_row_assembler: RTL

- Sits directly downstream of the systolic array top and consumes its skewed per-column result stream (read_out, o_data).
- Each column emits results at a different cycle, so the block buffers each column independently and re-aligns them into complete output rows.
- Each assembled row is post-processed (optional ReLU, rounding right-shift, saturation to W_BITWIDTH) and presented on a valid/ready interface to the next stage (output writeback / next-layer activation loader).

---
 rtl/output_row_assembler_pkg.sv | 19 +
 rtl/output_row_assembler_if.sv | 16 +
 rtl/output_row_assembler_col_fifo.sv | 48 ++++
 rtl/output_row_assembler.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/output_row_assembler_pkg.sv
// Shared types and constants for the output row assembler that sits behind the systolic array.
package output_row_assembler_pkg;

  localparam int sys_cols       = 4;
  localparam int P_BITWIDTH     = 32;
  localparam int W_BITWIDTH     = 8;
  localparam int OUT_FIFO_DEPTH = 8;

  typedef logic signed [P_BITWIDTH-1:0] psum_t;
  typedef logic signed [W_BITWIDTH-1:0] out_elem_t;
  typedef out_elem_t [sys_cols-1:0]     out_row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } oa_state_t;

endpackage

// File: rtl/output_row_assembler_if.sv
// Valid/ready row bus from the assembler to the writeback / next-layer loader.
interface output_row_assembler_if
  import output_row_assembler_pkg::*;
#(
  parameter int SYS_COLS = sys_cols,
  parameter int W_BW     = W_BITWIDTH
) ();

  logic                           row_valid;
  logic                           row_ready;
  logic [SYS_COLS-1:0][W_BW-1:0]  row_data;

  modport master (output row_valid, output row_data, input row_ready);
  modport slave  (input row_valid, input row_data, output row_ready);

endinterface

// File: rtl/output_row_assembler_col_fifo.sv
// Single-clock show-ahead FIFO holding one array column's partial sums.
module output_row_assembler_col_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO still takes a write when the same edge frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/output_row_assembler.sv
// Re-aligns skewed per-column array results into rows, then ReLU / rounding shift / saturation.
module output_row_assembler
  import output_row_assembler_pkg::*;
#(
  parameter int SYS_COLS   = sys_cols,
  parameter int P_BW       = P_BITWIDTH,
  parameter int W_BW       = W_BITWIDTH,
  parameter int FIFO_DEPTH = OUT_FIFO_DEPTH,
  parameter int ROW_CNT_W  = 16,
  parameter int SHIFT_W    = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ROW_CNT_W-1:0]           cfg_rows,
  input  logic [SHIFT_W-1:0]             cfg_shift,
  input  logic                           cfg_relu,
  input  logic [SYS_COLS-1:0]            read_out,
  input  logic [SYS_COLS-1:0][P_BW-1:0]  o_data,
  output_row_assembler_if.master         row,
  output logic                           busy,
  output logic                           done,
  output logic                           err_overflow
);

  localparam logic signed [P_BW:0] SAT_MAX = (P_BW+1)'((2 ** (W_BW-1)) - 1);
  localparam logic signed [P_BW:0] SAT_MIN = -SAT_MAX - (P_BW+1)'(1);

  oa_state_t                     state, state_next;
  logic [ROW_CNT_W-1:0]          cfg_rows_q, row_cnt, row_cnt_next, pop_cnt;
  logic [SHIFT_W-1:0]            cfg_shift_q;
  logic                          cfg_relu_q;
  logic                          row_valid_q, err_q;
  logic [SYS_COLS-1:0][W_BW-1:0] row_data_q, processed;
  logic [SYS_COLS-1:0][P_BW-1:0] fifo_dout;
  logic [SYS_COLS-1:0]           push, full, empty;
  logic                          pop, hs, overflow;

  // Rounding add is done one bit wider so the largest positive sum cannot wrap.
  function automatic logic [W_BW-1:0] post_process(input logic signed [P_BW-1:0] x,
                                                   input logic [SHIFT_W-1:0]     sh,
                                                   input logic                   relu);
    logic signed [P_BW:0] v;
    logic signed [P_BW:0] half;
    if (relu && x < 0) v = '0;
    else               v = (P_BW+1)'(x);
    if (sh != '0) begin
      half = (P_BW+1)'(1) << (sh - SHIFT_W'(1));
      v    = (v + half) >>> sh;
    end
    if (v > SAT_MAX)      return SAT_MAX[W_BW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[W_BW-1:0];
    else                  return v[W_BW-1:0];
  endfunction

  for (genvar j = 0; j < SYS_COLS; j++) begin : g_col
    output_row_assembler_col_fifo #(.WIDTH(P_BW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (start),
      .push  (push[j]),
      .pop   (pop),
      .din   (o_data[j]),
      .dout  (fifo_dout[j]),
      .full  (full[j]),
      .empty (empty[j])
    );
  end

  assign push         = (state == RUN) ? read_out : '0;
  assign hs           = row_valid_q && row.row_ready;
  assign pop          = (state == RUN) && (&(~empty)) && (!row_valid_q || row.row_ready)
                        && (pop_cnt < cfg_rows_q);
  assign overflow     = |(push & full) && !pop;
  assign row_cnt_next = row_cnt + ROW_CNT_W'(hs);

  always_comb begin
    processed = '0;
    for (int j = 0; j < SYS_COLS; j++) begin
      processed[j] = post_process(fifo_dout[j], cfg_shift_q, cfg_relu_q);
    end
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (row_cnt_next == cfg_rows_q) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_cnt     <= '0;
      pop_cnt     <= '0;
      err_q       <= 1'b0;
      cfg_rows_q  <= '0;
      cfg_shift_q <= '0;
      cfg_relu_q  <= 1'b0;
    end else if (start) begin
      row_valid_q <= 1'b0;
      row_data_q  <= '0;
      row_cnt     <= '0;
      pop_cnt     <= '0;
      err_q       <= 1'b0;
      cfg_rows_q  <= cfg_rows;
      cfg_shift_q <= cfg_shift;
      cfg_relu_q  <= cfg_relu;
    end else begin
      if (pop) begin
        row_valid_q <= 1'b1;
        row_data_q  <= processed;
        pop_cnt     <= pop_cnt + ROW_CNT_W'(1);
      end else if (hs) begin
        row_valid_q <= 1'b0;
      end
      row_cnt <= row_cnt_next;
      if (overflow) err_q <= 1'b1;
    end
  end

  assign row.row_valid = row_valid_q;
  assign row.row_data  = row_data_q;
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign err_overflow  = err_q;

endmodule
